// File: rtl/sd_otf_if.sv
// sd_otf_if: digit-stream and result bundle for the on-the-fly converter.
//   start        begin/restart a conversion
//   digit_valid  digit_in carries a digit this cycle
//   digit_in     signed digit {plus,minus}: 10=+1, 01=-1, 00=0
//   ready        converter is accepting digits
//   q_out        Q, signed, in units of 2^-NUM_DIGITS
//   qm_out       QM = Q - 1 unit
//   done         one-cycle completion pulse
//   digit_err    sticky: illegal digit 11 seen in this conversion
// master drives the digit stream, slave is the converter.
interface sd_otf_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                  start;
  logic                  digit_valid;
  logic [1:0]            digit_in;
  logic                  ready;
  logic [NUM_DIGITS:0]   q_out;
  logic [NUM_DIGITS:0]   qm_out;
  logic                  done;
  logic                  digit_err;

  modport master (
    output start, digit_valid, digit_in,
    input  ready, q_out, qm_out, done, digit_err
  );

  modport slave (
    input  start, digit_valid, digit_in,
    output ready, q_out, qm_out, done, digit_err
  );
endinterface

// File: rtl/sd_otf_converter.sv
// sd_otf_converter: radix-2 MSB-first signed-digit to two's-complement
// on-the-fly converter. Keeps Q and QM = Q - 1 so every digit is absorbed
// by a shift/select, never a carry-propagate add.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sd_otf_if slave: start/digit_valid/digit_in in,
//          ready/q_out/qm_out/done/digit_err out
module sd_otf_converter #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic     clk,
  input  logic     rst_n,
  sd_otf_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_DIGITS:0] q_q, q_d;
  logic [NUM_DIGITS:0] qm_q, qm_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    count_d = count_q;
    err_d   = err_q;

    // start restarts from any state and takes priority over a digit
    if (bus.start) begin
      state_d = CONVERT;
      q_d     = '0;
      qm_d    = '1;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CONVERT: begin
          if (bus.digit_valid) begin
            unique case (bus.digit_in)
              2'b10: begin
                q_d  = {q_q[NUM_DIGITS-1:0], 1'b1};
                qm_d = {q_q[NUM_DIGITS-1:0], 1'b0};
              end
              2'b01: begin
                q_d  = {qm_q[NUM_DIGITS-1:0], 1'b1};
                qm_d = {qm_q[NUM_DIGITS-1:0], 1'b0};
              end
              default: begin
                // 00, and illegal 11 handled as zero
                q_d  = {q_q[NUM_DIGITS-1:0], 1'b0};
                qm_d = {qm_q[NUM_DIGITS-1:0], 1'b1};
              end
            endcase
            err_d   = err_q | (bus.digit_in == 2'b11);
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(NUM_DIGITS - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ready     = (state_q == CONVERT);
  assign bus.done      = (state_q == DONE);
  assign bus.q_out     = q_q;
  assign bus.qm_out    = qm_q;
  assign bus.digit_err = err_q;

endmodule

// File: tb/tb_sd_otf_converter.sv
// tb_sd_otf_converter: directed bench for sd_otf_converter (NUM_DIGITS=4).
// Expected per-digit Q/QM and final results are queued by the stimulus and
// consumed by a monitor whenever the DUT accepts a digit or pulses done.
module tb_sd_otf_converter;
  localparam int unsigned N = 4;
  localparam logic [1:0] DP = 2'b10;
  localparam logic [1:0] DM = 2'b01;
  localparam logic [1:0] DZ = 2'b00;
  localparam logic [1:0] DX = 2'b11;

  typedef struct packed {
    logic [N:0] q;
    logic [N:0] qm;
    logic       err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_otf_if #(.NUM_DIGITS(N)) bus ();

  sd_otf_converter #(.NUM_DIGITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t step_q[$];
  res_t done_q[$];
  res_t se, de;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic acc = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: note acceptance at the edge, compare on the following negedge
  always @(posedge clk) acc <= bus.ready && bus.digit_valid && !bus.start;

  always @(negedge clk) begin
    if (acc) begin
      if (step_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL step_unexpected: digit accepted with nothing expected at %0t", $time);
      end else begin
        se = step_q.pop_front();
        check("step_q", bus.q_out, se.q);
        check("step_qm", bus.qm_out, se.qm);
      end
    end
    if (bus.done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done pulse with nothing expected at %0t", $time);
      end else begin
        de = done_q.pop_front();
        check("done_q", bus.q_out, de.q);
        check("done_qm", bus.qm_out, de.qm);
        check("done_err", bus.digit_err, de.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(logic [1:0] d, logic [N:0] eq, logic [N:0] eqm);
    bus.digit_valid = 1'b1;
    bus.digit_in    = d;
    step_q.push_back(res_t'{q: eq, qm: eqm, err: 1'b0});
    tick();
    bus.digit_valid = 1'b0;
    bus.digit_in    = DZ;
  endtask

  task automatic expect_done(logic [N:0] eq, logic [N:0] eqm, logic e);
    done_q.push_back(res_t'{q: eq, qm: eqm, err: e});
  endtask

  // called right after the last digit edge
  task automatic done_timing();
    @(negedge clk);
    check("done_rise", bus.done, 1'b1);
    check("done_ready", bus.ready, 1'b0);
    @(negedge clk);
    check("done_fall", bus.done, 1'b0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = DZ;

    // reset state
    #12;
    check("rst_q", bus.q_out, 5'b00000);
    check("rst_qm", bus.qm_out, 5'b11111);
    check("rst_ready", bus.ready, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.digit_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // +1,-1,0,+1 -> +5/16
    do_start();
    check("start_ready", bus.ready, 1'b1);
    send(DP, 5'b00001, 5'b00000);
    send(DM, 5'b00001, 5'b00000);
    send(DZ, 5'b00010, 5'b00001);
    expect_done(5'b00101, 5'b00100, 1'b0);
    send(DP, 5'b00101, 5'b00100);
    done_timing();

    // four -1 -> -15/16
    do_start();
    send(DM, 5'b11111, 5'b11110);
    send(DM, 5'b11101, 5'b11100);
    send(DM, 5'b11001, 5'b11000);
    expect_done(5'b10001, 5'b10000, 1'b0);
    send(DM, 5'b10001, 5'b10000);
    done_timing();

    // four +1 with 3-cycle gaps
    do_start();
    expect_done(5'b01111, 5'b01110, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(DP, 5'((1 << (i + 1)) - 1), 5'((1 << (i + 1)) - 2));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check("gap_hold", bus.q_out, 5'((1 << (i + 1)) - 1));
          check("gap_nodone", bus.done, 1'b0);
          tick();
        end
      end
    end
    done_timing();

    // abort after two digits; restart coincides with a dropped digit
    do_start();
    send(DP, 5'b00001, 5'b00000);
    send(DP, 5'b00011, 5'b00010);
    bus.start       = 1'b1;
    bus.digit_valid = 1'b1;
    bus.digit_in    = DP;
    tick();
    bus.start       = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = DZ;
    check("abort_q", bus.q_out, 5'b00000);
    check("abort_qm", bus.qm_out, 5'b11111);
    send(DZ, 5'b00000, 5'b11111);
    send(DZ, 5'b00000, 5'b11111);
    send(DZ, 5'b00000, 5'b11111);
    expect_done(5'b00001, 5'b00000, 1'b0);
    send(DP, 5'b00001, 5'b00000);
    done_timing();

    // illegal digit 11 mid-stream
    do_start();
    send(DP, 5'b00001, 5'b00000);
    send(DX, 5'b00010, 5'b00001);
    check("err_set", bus.digit_err, 1'b1);
    send(DZ, 5'b00100, 5'b00011);
    expect_done(5'b01000, 5'b00111, 1'b1);
    send(DZ, 5'b01000, 5'b00111);
    done_timing();
    check("err_hold_idle", bus.digit_err, 1'b1);
    check("q_hold_idle", bus.q_out, 5'b01000);
    do_start();
    check("err_clear", bus.digit_err, 1'b0);

    // reset during the 3rd digit
    send(DP, 5'b00001, 5'b00000);
    send(DP, 5'b00011, 5'b00010);
    bus.digit_valid = 1'b1;
    bus.digit_in    = DP;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", bus.q_out, 5'b00000);
    check("mid_rst_qm", bus.qm_out, 5'b11111);
    check("mid_rst_ready", bus.ready, 1'b0);
    tick();
    bus.digit_valid = 1'b0;
    check("mid_rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.digit_valid = 1'b1;
    bus.digit_in    = DP;
    tick();
    bus.digit_valid = 1'b0;
    tick();
    check("idle_ign_q", bus.q_out, 5'b00000);
    check("idle_ign_qm", bus.qm_out, 5'b11111);
    check("idle_ign_ready", bus.ready, 1'b0);
    check("idle_ign_done", bus.done, 1'b0);

    repeat (3) tick();
    check("done_count", done_cnt, 5);
    while (step_q.size() != 0) begin
      se = step_q.pop_front();
      checks++; errors++;
      $display("FAIL step_missing: expected q %0h never observed", se.q);
    end
    while (done_q.size() != 0) begin
      de = done_q.pop_front();
      checks++; errors++;
      $display("FAIL done_missing: expected q %0h never observed", de.q);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
